// File: rtl/txline_arbiter_pkg.sv
// Shared definitions for the txline arbiter: line terminators and arbiter state encoding.
package txline_arbiter_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0a;
  localparam logic [7:0] CHAR_CR = 8'h0d;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  // A line ends on either LF or CR.
  function automatic logic is_eol(input logic [7:0] b);
    return (b == CHAR_LF) || (b == CHAR_CR);
  endfunction

endpackage

// File: rtl/txline_arbiter_if.sv
// Requester-side and txuart-side signals of the line arbiter.
interface txline_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]   i_stb;
  logic [8*NREQ-1:0] i_data;
  logic [NREQ-1:0]   o_busy;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;
  logic [NREQ-1:0]   o_grant;

  modport slave (
    input  i_stb, i_data, i_tx_busy,
    output o_busy, o_tx_stb, o_tx_data, o_grant
  );

  modport master (
    output i_stb, i_data, i_tx_busy,
    input  o_busy, o_tx_stb, o_tx_data, o_grant
  );

endinterface

// File: rtl/txline_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         pick_o,
  output logic                 valid_o
);

  localparam int unsigned PW = $clog2(N);

  int unsigned k;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[PW'(k)]) begin
        pick_o[PW'(k)] = 1'b1;
        valid_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/txline_arbiter.sv
// Shares one txuart between NREQ byte streams at line granularity; an owner
// keeps the transmitter until LF/CR, MAXLINE bytes, or an idle timeout.
module txline_arbiter
  import txline_arbiter_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned MAXLINE      = 80,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input logic            i_clk,
  input logic            i_reset,
  txline_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAXLINE + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e      state_q;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   rr_q;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [IW-1:0]   icnt_q, icnt_d;

  logic [NREQ-1:0] pick;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic            granted;
  logic            cur_stb;
  logic [7:0]      cur_data;
  logic            xfer;
  logic            rel_c;
  logic [PW-1:0]   rr_next;
  logic [NREQ-1:0] busy_c;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i  (bus.i_stb),
    .ptr_i  (rr_q),
    .pick_o (pick),
    .valid_o(pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Owner's byte stream, selected by the registered grant index.
  always_comb begin
    cur_stb  = 1'b0;
    cur_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx_q == PW'(i)) begin
        cur_stb  = bus.i_stb[i];
        cur_data = bus.i_data[8*i +: 8];
      end
    end
  end

  assign granted = (state_q == ST_GRANTED);
  assign xfer    = granted && cur_stb && !bus.i_tx_busy;
  assign rr_next = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);

  always_comb begin
    bcnt_d = bcnt_q;
    icnt_d = icnt_q;
    if (xfer) begin
      bcnt_d = (bcnt_q == BW'(MAXLINE)) ? bcnt_q : bcnt_q + BW'(1);
      icnt_d = '0;
    end else if (icnt_q != IW'(IDLE_TIMEOUT)) begin
      icnt_d = icnt_q + IW'(1);
    end
  end

  // Coincident causes collapse into a single release.
  assign rel_c = (xfer && (is_eol(cur_data) || (bcnt_d == BW'(MAXLINE))))
              || (granted && !xfer && (icnt_d == IW'(IDLE_TIMEOUT)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      bcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANTED;
            grant_q <= pick;
            gidx_q  <= pick_idx;
          end
        end
        ST_GRANTED: begin
          if (rel_c) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= rr_next;
            bcnt_q  <= '0;
            icnt_q  <= '0;
          end else begin
            bcnt_q <= bcnt_d;
            icnt_q <= icnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c = '1;
    if (granted) busy_c[gidx_q] = bus.i_tx_busy;
  end

  assign bus.o_busy    = busy_c;
  assign bus.o_grant   = grant_q;
  assign bus.o_tx_stb  = granted && cur_stb;
  assign bus.o_tx_data = granted ? cur_data : 8'h00;

endmodule

// File: tb/tb_txline_arbiter.sv
// Bench for txline_arbiter: randomized line traffic against a cycle-level
// reference of the arbitration rules, plus directed line/contention scenarios.
module tb_txline_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MAXLINE = 80;
  localparam int unsigned TMO     = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  txline_arbiter_if #(.NREQ(NREQ)) bus ();

  txline_arbiter #(
    .NREQ(NREQ), .MAXLINE(MAXLINE), .IDLE_TIMEOUT(TMO)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_vec;
  int n_err;

  logic [7:0] rq [NREQ][$];
  logic [7:0] wire_q[$];
  int tx_cnt;

  int m_owner;
  int m_ptr;
  int m_bytes;
  int m_idle;

  task automatic push_line(input int k, input int len, input logic [7:0] term);
    for (int i = 0; i < len - 1; i++) rq[k].push_back(8'($urandom_range(32, 126)));
    if (term == 8'h00) rq[k].push_back(8'($urandom_range(32, 126)));
    else               rq[k].push_back(term);
  endtask

  function automatic int first_diff(input logic [7:0] e[$], input logic [7:0] a[$]);
    if (e.size() != a.size()) return -2;
    for (int i = 0; i < e.size(); i++) if (e[i] !== a[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (rq[k].size() > 0) begin
        bus.i_stb[k]          = 1'b1;
        bus.i_data[8*k +: 8]  = rq[k][0];
      end else begin
        bus.i_stb[k]          = 1'b0;
        bus.i_data[8*k +: 8]  = 8'($urandom);
      end
    end
    bus.i_tx_busy = (tx_cnt > 0);
  endtask

  // One clock: drive, compare against the reference, advance the reference, txuart and sources.
  task automatic cycle();
    logic [NREQ-1:0]   exp_grant, exp_busy, stb_s, acc;
    logic [8*NREQ-1:0] dat_s;
    logic              exp_stb, txb_s, rst_s, act_xfer, x, rel;
    logic [7:0]        ob;
    int                k;
    bit                found;
    drive();
    #1;
    exp_grant = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
    exp_busy  = '1;
    exp_stb   = 1'b0;
    if (m_owner >= 0) begin
      exp_busy[m_owner] = bus.i_tx_busy;
      exp_stb           = bus.i_stb[m_owner];
    end
    n_vec++;
    if (bus.o_grant !== exp_grant) begin
      n_err++; $display("FAIL grant @%0t got %b exp %b", $time, bus.o_grant, exp_grant);
    end
    n_vec++;
    if (bus.o_busy !== exp_busy) begin
      n_err++; $display("FAIL busy @%0t got %b exp %b", $time, bus.o_busy, exp_busy);
    end
    n_vec++;
    if (bus.o_tx_stb !== exp_stb) begin
      n_err++; $display("FAIL tx_stb @%0t got %b exp %b", $time, bus.o_tx_stb, exp_stb);
    end
    if (exp_stb) begin
      ob = bus.i_data[8*m_owner +: 8];
      n_vec++;
      if (bus.o_tx_data !== ob) begin
        n_err++; $display("FAIL tx_data @%0t got %h exp %h", $time, bus.o_tx_data, ob);
      end
    end
    act_xfer = bus.o_tx_stb && !bus.i_tx_busy;
    if (act_xfer) wire_q.push_back(bus.o_tx_data);
    acc   = bus.i_stb & ~bus.o_busy;
    stb_s = bus.i_stb;
    dat_s = bus.i_data;
    txb_s = bus.i_tx_busy;
    rst_s = rst;
    @(posedge clk);
    if (rst_s) begin
      m_owner = -1; m_ptr = 0; m_bytes = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (!found && stb_s[k]) begin
          m_owner = k; found = 1'b1;
        end
      end
      m_bytes = 0; m_idle = 0;
    end else begin
      x   = stb_s[m_owner] && !txb_s;
      rel = 1'b0;
      if (x) begin
        ob = dat_s[8*m_owner +: 8];
        m_bytes++; m_idle = 0;
        if (ob == 8'h0a || ob == 8'h0d || m_bytes == MAXLINE) rel = 1'b1;
      end else begin
        m_idle++;
        if (m_idle == TMO) rel = 1'b1;
      end
      if (rel) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_bytes = 0; m_idle = 0;
      end
    end
    if (act_xfer) tx_cnt = $urandom_range(0, 2);
    else if (tx_cnt > 0) tx_cnt--;
    for (int j = 0; j < NREQ; j++) if (acc[j] && rq[j].size() > 0) rq[j].delete(0);
    @(negedge clk);
  endtask

  task automatic wait_wire(input int n, input int budget, input string what);
    int c = 0;
    while (wire_q.size() < n && c < budget) begin cycle(); c++; end
    if (wire_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout got %0d bytes need %0d", what, wire_q.size(), n);
    end
  endtask

  task automatic run_until_idle(input int budget, input string what);
    int  c = 0;
    bit  busy_src;
    busy_src = 1'b1;
    while (busy_src && c < budget) begin
      busy_src = (bus.o_grant != '0);
      for (int k = 0; k < NREQ; k++) if (rq[k].size() > 0) busy_src = 1'b1;
      if (busy_src) begin cycle(); c++; end
    end
    if (busy_src) begin
      n_vec++; n_err++; $display("FAIL %s idle timeout after %0d cycles", what, c);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < NREQ; k++) rq[k].delete();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    wire_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_owner = -1; m_ptr = 0; m_bytes = 0; m_idle = 0;
    n_vec++;
    if (bus.o_grant !== '0) begin n_err++; $display("FAIL reset_grant got %b exp 0000", bus.o_grant); end
    n_vec++;
    if (bus.o_busy !== '1) begin n_err++; $display("FAIL reset_busy got %b exp 1111", bus.o_busy); end
    n_vec++;
    if (bus.o_tx_stb !== 1'b0) begin n_err++; $display("FAIL reset_tx_stb got %b exp 0", bus.o_tx_stb); end
    rst = 1'b0;
    wire_q.delete();
  endtask

  task automatic test_single_line();
    logic [7:0] e[$];
    int d;
    e = '{8'h41, 8'h42, 8'h0a};
    rq[2] = e;
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b exp 0100", bus.o_grant); end
    n_vec++;
    if (wire_q.size() != 0) begin n_err++; $display("FAIL single_arb_xfer got %0d bytes exp 0", wire_q.size()); end
    wait_wire(3, 40, "single_line");
    n_vec++;
    if (bus.o_grant !== 4'b0000) begin n_err++; $display("FAIL single_release got %b exp 0000", bus.o_grant); end
    d = first_diff(e, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL single_wire diff at %0d got %0d bytes exp 3", d, wire_q.size()); end
    run_until_idle(50, "single_line");
  endtask

  task automatic test_contention();
    logic [7:0] l0[$], l3[$], e[$];
    int d;
    do_reset();
    push_line(0, $urandom_range(3, 10), 8'h0a);
    push_line(3, $urandom_range(3, 10), 8'h0d);
    l0 = rq[0]; l3 = rq[3];
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b0001) begin n_err++; $display("FAIL cont_first got %b exp 0001", bus.o_grant); end
    run_until_idle(300, "contention");
    e = {l0, l3};
    d = first_diff(e, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL cont_order diff at %0d got %0d exp %0d bytes", d, wire_q.size(), e.size()); end
    push_line(0, 4, 8'h0a);
    run_until_idle(100, "cont_ptr_setup");
    wire_q.delete();
    push_line(0, $urandom_range(3, 10), 8'h0a);
    push_line(3, $urandom_range(3, 10), 8'h0a);
    l0 = rq[0]; l3 = rq[3];
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b1000) begin n_err++; $display("FAIL cont_ptr1 got %b exp 1000", bus.o_grant); end
    run_until_idle(300, "contention2");
    e = {l3, l0};
    d = first_diff(e, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL cont_order2 diff at %0d got %0d exp %0d bytes", d, wire_q.size(), e.size()); end
  endtask

  task automatic test_maxline();
    logic [7:0] l1[$], l2[$], e[$];
    int d;
    do_reset();
    for (int i = 0; i < 100; i++) rq[1].push_back(8'($urandom_range(32, 126)));
    l1 = rq[1];
    wait_wire(10, 100, "maxline_start");
    push_line(2, 5, 8'h0a);
    l2 = rq[2];
    wait_wire(80, 400, "maxline_80");
    n_vec++;
    if (bus.o_grant !== 4'b0000 || wire_q.size() != 80) begin
      n_err++; $display("FAIL maxline_release got grant %b bytes %0d exp 0000 80", bus.o_grant, wire_q.size());
    end
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b0100) begin n_err++; $display("FAIL maxline_next got %b exp 0100", bus.o_grant); end
    run_until_idle(400, "maxline");
    for (int i = 0; i < 80; i++) e.push_back(l1[i]);
    for (int i = 0; i < l2.size(); i++) e.push_back(l2[i]);
    for (int i = 80; i < 100; i++) e.push_back(l1[i]);
    d = first_diff(e, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL maxline_wire diff at %0d got %0d exp %0d bytes", d, wire_q.size(), e.size()); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    push_line(0, 3, 8'h00);
    wait_wire(3, 50, "timeout_bytes");
    push_line(2, 4, 8'h0a);
    cnt = 0;
    while (bus.o_grant != '0 && cnt < TMO + 10) begin cycle(); cnt++; end
    n_vec++;
    if (cnt != TMO) begin n_err++; $display("FAIL timeout_len got %0d clocks exp %0d", cnt, TMO); end
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b0100) begin n_err++; $display("FAIL timeout_next got %b exp 0100", bus.o_grant); end
    run_until_idle(100, "timeout");
  endtask

  task automatic test_reset_midline();
    logic [7:0] l1[$];
    int n0, c, d;
    logic [7:0] sent[$];
    do_reset();
    push_line(1, 31, 8'h0a);
    l1 = rq[1];
    c = 0;
    while (!(wire_q.size() >= 5 && tx_cnt > 0) && c < 200) begin cycle(); c++; end
    n_vec++;
    if (!(wire_q.size() >= 5 && tx_cnt > 0)) begin n_err++; $display("FAIL rstmid_setup got %0d bytes", wire_q.size()); end
    n0 = wire_q.size();
    rst = 1'b1;
    cycle();
    n_vec++;
    if (bus.o_grant !== '0 || bus.o_busy !== '1 || bus.o_tx_stb !== 1'b0) begin
      n_err++; $display("FAIL rstmid_outputs got grant %b busy %b stb %b exp 0000 1111 0", bus.o_grant, bus.o_busy, bus.o_tx_stb);
    end
    rq[1].delete();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < n0; i++) sent.push_back(l1[i]);
    d = first_diff(sent, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL rstmid_nodup diff at %0d got %0d bytes exp %0d", d, wire_q.size(), n0); end
    run_until_idle(50, "rstmid");
    wire_q.delete();
  endtask

  task automatic test_cr_at_80();
    logic [7:0] l1[$], l2[$], e[$];
    int d;
    do_reset();
    push_line(1, 80, 8'h0d);
    push_line(1, 6, 8'h0a);
    l1 = rq[1];
    wait_wire(70, 300, "cr80_start");
    push_line(2, 5, 8'h0a);
    l2 = rq[2];
    wait_wire(80, 100, "cr80_80");
    n_vec++;
    if (bus.o_grant !== 4'b0000) begin n_err++; $display("FAIL cr80_release got %b exp 0000", bus.o_grant); end
    cycle();
    n_vec++;
    if (bus.o_grant !== 4'b0100) begin n_err++; $display("FAIL cr80_ptr got %b exp 0100", bus.o_grant); end
    run_until_idle(300, "cr80");
    for (int i = 0; i < 80; i++) e.push_back(l1[i]);
    for (int i = 0; i < l2.size(); i++) e.push_back(l2[i]);
    for (int i = 80; i < l1.size(); i++) e.push_back(l1[i]);
    d = first_diff(e, wire_q);
    n_vec++;
    if (d != -1) begin n_err++; $display("FAIL cr80_wire diff at %0d got %0d exp %0d bytes", d, wire_q.size(), e.size()); end
  endtask

  task automatic test_random();
    logic [7:0] term;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 3))
            0:       term = 8'h0d;
            1:       term = 8'h00;
            default: term = 8'h0a;
          endcase
          push_line(k, $urandom_range(1, 90), term);
        end
      end
      repeat ($urandom_range(0, 3)) cycle();
      run_until_idle(3000, "random");
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    tx_cnt  = 0;
    rst     = 1'b1;
    m_owner = -1; m_ptr = 0; m_bytes = 0; m_idle = 0;
    test_reset();
    test_single_line();
    test_contention();
    test_maxline();
    test_timeout();
    test_reset_midline();
    test_cr_at_80();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
